// File: rtl/prewish_pkg.sv
// prewish shared types: mask width, counter defaults and the
// dipload FSM encoding.
package prewish_pkg;

  localparam int MASK_W            = 8;
  localparam int DEBOUNCE_BITS_DEF = 16;
  localparam int REPEAT_BITS_DEF   = 24;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    HELD = 2'b10
  } dip_state_e;

endpackage

// File: rtl/prewish_debouncer.sv
// prewish_debouncer: 2-flop synchroniser plus a counter that only
// lets a level through after it has held for 2^DEBOUNCE_BITS cycles.
module prewish_debouncer
  import prewish_pkg::*;
#(
  parameter int DEBOUNCE_BITS = DEBOUNCE_BITS_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic stable
);

  logic [1:0]               sync_q;
  logic [DEBOUNCE_BITS-1:0] db_ct;

  // sync the raw level, then flip stable once it differs long enough
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
      stable <= 1'b0;
      db_ct  <= '0;
    end else begin
      sync_q <= {sync_q[0], din};
      if (sync_q[1] == stable) begin
        db_ct <= '0;
      end else if (&db_ct) begin
        stable <= ~stable;
        db_ct  <= '0;
      end else begin
        db_ct <= db_ct + {{(DEBOUNCE_BITS-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/prewish_dipload.sv
// prewish_dipload: debounced load button strobes the synced DIP mask
// to the mentor. Define PREWISH_DIPLOAD_REPEAT_EN for auto-repeat.
module prewish_dipload
  import prewish_pkg::*;
#(
  parameter int DEBOUNCE_BITS = DEBOUNCE_BITS_DEF,
  parameter int REPEAT_BITS   = REPEAT_BITS_DEF
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  input  logic              i_button_n,
  input  logic [MASK_W-1:0] i_dip,
  output logic              STB_O,
  output logic [MASK_W-1:0] DAT_O,
  output logic              o_alive
);

  if (DEBOUNCE_BITS < 2 || REPEAT_BITS < 2) begin : g_bad_width
    $error("prewish_dipload: counter widths must be >= 2");
  end

  dip_state_e        state;
  dip_state_e        state_nx;
  logic              stable;
  logic              stable_q;
  logic              rise;
  logic              rep_wrap;
  logic [MASK_W-1:0] dip_s1;
  logic [MASK_W-1:0] dip_s2;

  prewish_debouncer #(
    .DEBOUNCE_BITS (DEBOUNCE_BITS)
  ) u_btn (
    .clk    (CLK_I),
    .rst_n  (RST_I),
    .din    (~i_button_n),
    .stable (stable)
  );

  assign rise    = stable & ~stable_q;
  assign o_alive = stable;

`ifdef PREWISH_DIPLOAD_REPEAT_EN
  logic [REPEAT_BITS-1:0] rep_ct;

  // count cycles spent in HELD; cleared outside HELD and on release
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      rep_ct <= '0;
    end else if (state != HELD || !stable) begin
      rep_ct <= '0;
    end else begin
      rep_ct <= rep_ct + {{(REPEAT_BITS-1){1'b0}}, 1'b1};
    end
  end

  assign rep_wrap = &rep_ct;
`else
  assign rep_wrap = 1'b0;
`endif

  // dip synchroniser, press-edge history and FSM state register
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      dip_s1   <= '0;
      dip_s2   <= '0;
      stable_q <= 1'b0;
      state    <= IDLE;
    end else begin
      dip_s1   <= i_dip;
      dip_s2   <= dip_s1;
      stable_q <= stable;
      state    <= state_nx;
    end
  end

  // next-state: a press edge loads once, release returns to idle
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (rise) state_nx = LOAD;
      LOAD: state_nx = HELD;
      HELD: begin
        if (!stable) begin
          state_nx = IDLE;
        end else if (rep_wrap) begin
          state_nx = LOAD;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // strobe for one cycle out of LOAD and capture the synced mask
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      STB_O <= 1'b0;
      DAT_O <= '0;
    end else begin
      STB_O <= (state == LOAD);
      if (state == LOAD) begin
        DAT_O <= dip_s2;
      end
    end
  end

endmodule

// File: tb/tb_prewish_dipload.sv
// tb_prewish_dipload: directed stimulus with a strobe scoreboard;
// expected strobe cycle and mask are queued when the press is driven.
`timescale 1ns/1ps
module tb_prewish_dipload;
  import prewish_pkg::*;

  localparam int LAT  = 11;
  localparam int HOLD = 195;
  localparam int CHG  = 100;

  typedef struct {
    int          cyc;
    logic [7:0]  dat;
  } exp_t;

  logic       CLK_I      = 1'b0;
  logic       RST_I      = 1'b1;
  logic       i_button_n = 1'b1;
  logic [7:0] i_dip      = 8'h00;
  logic       STB_O;
  logic [7:0] DAT_O;
  logic       o_alive;

  int         cyc   = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         t0;
  exp_t       sb[$];
  exp_t       e_rep;
  logic [7:0] last_dat = 8'h00;

  prewish_dipload #(
    .DEBOUNCE_BITS (3),
    .REPEAT_BITS   (5)
  ) dut (
    .CLK_I      (CLK_I),
    .RST_I      (RST_I),
    .i_button_n (i_button_n),
    .i_dip      (i_dip),
    .STB_O      (STB_O),
    .DAT_O      (DAT_O),
    .o_alive    (o_alive)
  );

  always #5 CLK_I = ~CLK_I;

  always @(posedge CLK_I) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h (cycle %0d)",
             tag, obs, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK_I);
  endtask

  // press driven now: first sampled next edge, strobe LAT edges later
  task automatic expect_press(input logic [7:0] d);
    exp_t e;
    e.cyc = cyc + 1 + LAT;
    e.dat = d;
    sb.push_back(e);
    last_dat = d;
  endtask

  always @(negedge CLK_I) begin
    if (STB_O !== 1'b0) begin
      if (sb.size() == 0) begin
        check("stray_stb", {31'd0, STB_O}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("stb_cycle", cyc, e.cyc);
        check("stb_data", {24'd0, DAT_O}, {24'd0, e.dat});
      end
    end
  end

  initial begin
    // reset held with button pressed and all switches on
    RST_I      = 1'b0;
    i_button_n = 1'b0;
    i_dip      = 8'hFF;
    repeat (5) begin
      tick(1);
      check("rst_stb", {31'd0, STB_O}, 32'd0);
      check("rst_dat", {24'd0, DAT_O}, 32'd0);
      check("rst_alive", {31'd0, o_alive}, 32'd0);
    end
    i_button_n = 1'b1;
    i_dip      = 8'hA8;
    tick(1);
    RST_I = 1'b1;
    tick(3);

    // clean press, then long hold with a mid-hold dip change
    i_button_n = 1'b0;
    t0 = cyc;
    expect_press(8'hA8);
`ifdef PREWISH_DIPLOAD_REPEAT_EN
    for (int t = t0 + 1 + LAT + 33; t <= t0 + HOLD + 11; t += 33) begin
      e_rep.cyc = t;
      e_rep.dat = (t - 2 >= t0 + CHG + 1) ? 8'hCA : 8'hA8;
      sb.push_back(e_rep);
      last_dat = e_rep.dat;
    end
`endif
    tick(9);
    check("alive_pre", {31'd0, o_alive}, 32'd0);
    tick(1);
    check("alive_rise", {31'd0, o_alive}, 32'd1);
    check("dat_before_stb", {24'd0, DAT_O}, 32'd0);
    tick(CHG - 10);
    i_dip = 8'hCA;
    tick(HOLD - CHG);
    check("dat_after_hold", {24'd0, DAT_O}, {24'd0, last_dat});
    i_button_n = 1'b1;
    tick(30);
    check("alive_release", {31'd0, o_alive}, 32'd0);

    // second press with a new mask
    i_dip      = 8'h55;
    i_button_n = 1'b0;
    expect_press(8'h55);
    tick(30);
    i_button_n = 1'b1;
    tick(30);
    check("dat_second", {24'd0, DAT_O}, 32'h55);

    // bounce: three short pulses, then a steady press
    i_dip = 8'h3C;
    for (int p = 0; p < 3; p++) begin
      i_button_n = 1'b0;
      tick(5);
      i_button_n = 1'b1;
      tick(3);
    end
    check("bounce_alive", {31'd0, o_alive}, 32'd0);
    check("bounce_dat", {24'd0, DAT_O}, 32'h55);
    i_button_n = 1'b0;
    expect_press(8'h3C);
    tick(20);
    i_button_n = 1'b1;
    tick(30);

    // reset asserted in HELD with the button still down
    i_dip      = 8'h96;
    i_button_n = 1'b0;
    expect_press(8'h96);
    tick(20);
    check("held_alive", {31'd0, o_alive}, 32'd1);
    RST_I = 1'b0;
    #1;
    check("midrst_stb", {31'd0, STB_O}, 32'd0);
    check("midrst_dat", {24'd0, DAT_O}, 32'd0);
    check("midrst_alive", {31'd0, o_alive}, 32'd0);
    tick(3);
    check("midrst_hold_dat", {24'd0, DAT_O}, 32'd0);
    i_dip = 8'h69;
    RST_I = 1'b1;
    expect_press(8'h69);
    tick(20);
    i_button_n = 1'b1;
    tick(30);
    check("final_dat", {24'd0, DAT_O}, 32'h69);

    check("sb_drained", sb.size(), 32'd0);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      $display("FAIL missing_stb: absent at cycle %0d data %0h",
               e.cyc, e.dat);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
